// File: rtl/rt_counter_ctrl.sv
// Real-time clock counter: prescaled seconds/minutes/hours with a run/stop
// control FSM and a validated load handshake. All outputs are registered.
module rt_counter_ctrl #(
    parameter int TICK_DIV = 1000,
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HR_MOD   = 24,
    localparam int SW      = $clog2(SEC_MOD),
    localparam int MW      = $clog2(MIN_MOD),
    localparam int HW      = $clog2(HR_MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          load_req,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hr,
    output logic          load_ack,
    output logic          load_err,
    output logic [SW-1:0] sec_o,
    output logic [MW-1:0] min_o,
    output logic [HW-1:0] hr_o,
    output logic          sec_en,
    output logic          min_en,
    output logic          hr_en,
    output logic          day_wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_MOD - 1);
    localparam logic [MW-1:0] MIN_MAX   = MW'(MIN_MOD - 1);
    localparam logic [HW-1:0] HR_MAX    = HW'(HR_MOD - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_armed;
    logic [SW-1:0] r_sec;
    logic [MW-1:0] r_min;
    logic [HW-1:0] r_hr;
    logic          r_sec_en, r_min_en, r_hr_en, r_day_wrap;
    logic          r_load_ack, r_load_err;

    logic w_load_start;
    logic w_count;
    logic w_tick;
    logic w_load_ok;

    // The prescaler advances on every edge whose outcome is RUN, so a run
    // level change takes effect on the same edge in both directions.
    assign w_load_start = (r_state != ST_LOAD) && load_req && r_armed;
    assign w_count      = (r_state != ST_LOAD) && run && !w_load_start;
    assign w_tick       = w_count && (r_presc == PRESC_MAX);
    assign w_load_ok    = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) &&
                          (load_hr <= HR_MAX);

    always_ff @(posedge clk) begin
        // NOTE: pulse outputs default low each edge; sequential state uses <= only.
        r_sec_en   <= 1'b0;
        r_min_en   <= 1'b0;
        r_hr_en    <= 1'b0;
        r_day_wrap <= 1'b0;
        r_load_ack <= 1'b0;
        r_load_err <= 1'b0;
        if (reset) begin
            r_state <= ST_STOP;
            r_presc <= '0;
            r_armed <= 1'b1;
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
        end else begin
            if (!load_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_STOP, ST_RUN: begin
                    if (w_load_start) begin
                        r_state <= ST_LOAD;
                        r_armed <= 1'b0;
                    end else begin
                        r_state <= run ? ST_RUN : ST_STOP;
                        if (w_tick) begin
                            r_presc  <= '0;
                            r_sec_en <= 1'b1;
                            if (r_sec == SEC_MAX) begin
                                r_sec    <= '0;
                                r_min_en <= 1'b1;
                                if (r_min == MIN_MAX) begin
                                    r_min   <= '0;
                                    r_hr_en <= 1'b1;
                                    if (r_hr == HR_MAX) begin
                                        r_hr       <= '0;
                                        r_day_wrap <= 1'b1;
                                    end else begin
                                        r_hr <= r_hr + HW'(1);
                                    end
                                end else begin
                                    r_min <= r_min + MW'(1);
                                end
                            end else begin
                                r_sec <= r_sec + SW'(1);
                            end
                        end else if (w_count) begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    r_state    <= run ? ST_RUN : ST_STOP;
                    r_load_ack <= 1'b1;
                    if (w_load_ok) begin
                        r_sec    <= load_sec;
                        r_min    <= load_min;
                        r_hr     <= load_hr;
                        r_presc  <= '0;
                        r_sec_en <= 1'b1;
                        r_min_en <= 1'b1;
                        r_hr_en  <= 1'b1;
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    assign sec_o    = r_sec;
    assign min_o    = r_min;
    assign hr_o     = r_hr;
    assign sec_en   = r_sec_en;
    assign min_en   = r_min_en;
    assign hr_en    = r_hr_en;
    assign day_wrap = r_day_wrap;
    assign load_ack = r_load_ack;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_rt_counter_ctrl.sv
// Directed bench for rt_counter_ctrl with TICK_DIV=4: counting, rollover,
// load accept/reject, load/tick collision, pause and reset during load.
module tb_rt_counter_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SW = 6;
    localparam int MW = 6;
    localparam int HW = 5;

    logic          clk = 1'b0;
    logic          reset, run, load_req;
    logic [SW-1:0] load_sec;
    logic [MW-1:0] load_min;
    logic [HW-1:0] load_hr;
    logic          load_ack, load_err;
    logic [SW-1:0] sec_o;
    logic [MW-1:0] min_o;
    logic [HW-1:0] hr_o;
    logic          sec_en, min_en, hr_en, day_wrap;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rt_counter_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .load_req (load_req),
        .load_sec (load_sec),
        .load_min (load_min),
        .load_hr  (load_hr),
        .load_ack (load_ack),
        .load_err (load_err),
        .sec_o    (sec_o),
        .min_o    (min_o),
        .hr_o     (hr_o),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hr_en    (hr_en),
        .day_wrap (day_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int s, input int m, input int h);
        check({tag, ".sec"}, 32'(sec_o), 32'(s));
        check({tag, ".min"}, 32'(min_o), 32'(m));
        check({tag, ".hr"},  32'(hr_o),  32'(h));
    endtask

    task automatic check_pulses(input string tag, input bit s, input bit m, input bit h,
                                input bit d, input bit ack, input bit err);
        check({tag, ".sec_en"},   32'(sec_en),   32'(s));
        check({tag, ".min_en"},   32'(min_en),   32'(m));
        check({tag, ".hr_en"},    32'(hr_en),    32'(h));
        check({tag, ".day_wrap"}, 32'(day_wrap), 32'(d));
        check({tag, ".load_ack"}, 32'(load_ack), 32'(ack));
        check({tag, ".load_err"}, 32'(load_err), 32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        run      = 1'b0;
        load_req = 1'b0;
        load_sec = '0;
        load_min = '0;
        load_hr  = '0;
        step(2);
        check_time("reset", 0, 0, 0);
        check_pulses("reset", 0, 0, 0, 0, 0, 0);

        // Basic counting: tick on every 4th edge of run
        reset = 1'b0;
        run   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("count.c%0d.sec_en", c), 32'(sec_en), 32'(c % 4 == 0));
            check($sformatf("count.c%0d.min_en", c), 32'(min_en), 32'(0));
            if (c % 4 == 0)
                check($sformatf("count.c%0d.sec", c), 32'(sec_o), 32'(c / 4));
        end
        run = 1'b0;
        step(3);
        check_time("stop_hold", 3, 0, 0);
        check_pulses("stop_hold", 0, 0, 0, 0, 0, 0);

        // Invalid load in STOP: minutes out of range
        load_sec = 6'd5;
        load_min = 6'd60;
        load_hr  = 5'd1;
        load_req = 1'b1;
        step();
        check_pulses("bad_load.enter", 0, 0, 0, 0, 0, 0);
        step();
        check_pulses("bad_load.ack", 0, 0, 0, 0, 1, 1);
        check_time("bad_load.ack", 3, 0, 0);
        load_req = 1'b0;
        step();
        check_pulses("bad_load.after", 0, 0, 0, 0, 0, 0);
        check_time("bad_load.after", 3, 0, 0);

        // Valid load 23:59:59 then full rollover after 4 edges of run
        load_sec = 6'd59;
        load_min = 6'd59;
        load_hr  = 5'd23;
        load_req = 1'b1;
        step(2);
        check_pulses("load_max.ack", 1, 1, 1, 0, 1, 0);
        check_time("load_max.ack", 59, 59, 23);
        load_req = 1'b0;
        run      = 1'b1;
        step(3);
        check_pulses("rollover.pre", 0, 0, 0, 0, 0, 0);
        check_time("rollover.pre", 59, 59, 23);
        step();
        check_pulses("rollover", 1, 1, 1, 1, 0, 0);
        check_time("rollover", 0, 0, 0);
        step();
        check_pulses("rollover.after", 0, 0, 0, 0, 0, 0);

        // Pause at prescaler=2: two edges to the tick after resuming
        step();
        run = 1'b0;
        step(10);
        check_time("pause.hold", 0, 0, 0);
        check("pause.sec_en", 32'(sec_en), 32'(0));
        run = 1'b1;
        step();
        check("resume.e1.sec_en", 32'(sec_en), 32'(0));
        step();
        check("resume.e2.sec_en", 32'(sec_en), 32'(1));
        check_time("resume.e2", 1, 0, 0);

        // Load request arrives on the tick edge: the load wins
        step(3);
        load_sec = 6'd10;
        load_min = 6'd20;
        load_hr  = 5'd5;
        load_req = 1'b1;
        step();
        check_pulses("collide.enter", 0, 0, 0, 0, 0, 0);
        check_time("collide.enter", 1, 0, 0);
        step();
        check_pulses("collide.ack", 1, 1, 1, 0, 1, 0);
        check_time("collide.ack", 10, 20, 5);
        // load_req stays high: no second LOAD, tick 4 edges after leaving LOAD
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("post_load.c%0d.sec_en", c), 32'(sec_en), 32'(c == 4));
            check($sformatf("post_load.c%0d.load_ack", c), 32'(load_ack), 32'(0));
        end
        check_time("post_load", 11, 20, 5);
        load_req = 1'b0;
        step();

        // Reset during the LOAD cycle: nothing committed
        load_sec = 6'd1;
        load_min = 6'd2;
        load_hr  = 5'd3;
        load_req = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_time("rst_load", 0, 0, 0);
        check_pulses("rst_load", 0, 0, 0, 0, 0, 0);
        reset    = 1'b0;
        load_req = 1'b0;
        run      = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("rst_resume.c%0d.sec_en", c), 32'(sec_en), 32'(c == 4));
            check($sformatf("rst_resume.c%0d.load_ack", c), 32'(load_ack), 32'(0));
        end
        check_time("rst_resume", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
